// File: rtl/ysyx_23060096_regfile_sb.sv
// ysyx_23060096_regfile_sb
// Register file with a per-register busy scoreboard for an in-order issue
// pipeline. After reset, an INIT sweep clears one register per cycle. The
// block then enters RUN, where it serves NREAD combinational read ports
// with write-back bypass, tracks pending writes, and stalls WAW issues.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   raddr / rdata   NREAD packed read indices / read data (port k at slice k)
//   rbusy           per read port: indexed register has a pending write
//   w_en/waddr/wdata  write-back strobe, index, data
//   iss_valid/iss_rd  issue request reserving destination iss_rd
//   iss_ready       issue accepted this cycle
//   init_done       clear sweep complete, block usable
module ysyx_23060096_regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NREAD      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
  output logic [NREAD*DATA_WIDTH-1:0] rdata,
  output logic [NREAD-1:0]            rbusy,
  input  logic                        w_en,
  input  logic [ADDR_WIDTH-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic                        iss_valid,
  input  logic [ADDR_WIDTH-1:0]       iss_rd,
  output logic                        iss_ready,
  output logic                        init_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic                  r_init_done;
  logic [DEPTH-1:0]      r_busy;
  logic [DATA_WIDTH-1:0] r_rf [DEPTH];

  logic w_run;
  logic w_wb;
  logic w_iss_acc;

  // Every output is forced quiet while rst is held, even if the state
  // register still says RUN until the reset edge arrives.
  assign w_run     = (r_state == S_RUN) && !rst;
  assign w_wb      = w_run && w_en && (waddr != '0);
  // A busy destination may still issue when its write-back lands this cycle.
  assign iss_ready = w_run && ((iss_rd == '0) || !r_busy[iss_rd] ||
                               (w_en && (waddr == iss_rd)));
  assign w_iss_acc = iss_valid && iss_ready && (iss_rd != '0);
  assign init_done = r_init_done && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_INIT;
      r_idx       <= '0;
      r_init_done <= 1'b0;
      r_busy      <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_idx <= r_idx + ADDR_WIDTH'(1);
          if (r_idx == LAST_IDX) begin
            r_state     <= S_RUN;
            r_init_done <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_wb)
            r_busy[waddr] <= 1'b0;
          // Placed after the clear so a same-cycle reissue leaves busy set.
          if (w_iss_acc)
            r_busy[iss_rd] <= 1'b1;
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  // Storage has no reset of its own; the INIT sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_INIT)
        r_rf[r_idx] <= '0;
      else if (w_wb)
        r_rf[waddr] <= wdata;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_ra;
    logic [DATA_WIDTH-1:0] w_rd;

    assign w_ra = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_rd = (!w_run || (w_ra == '0))      ? '0    :
                  (w_en && (waddr == w_ra))     ? wdata :
                                                  r_rf[w_ra];
    assign rdata[k*DATA_WIDTH +: DATA_WIDTH] = w_rd;
    // Same-cycle write-back does not hide the busy bit.
    assign rbusy[k] = w_run && r_busy[w_ra];
  end

endmodule

// File: tb/tb_ysyx_23060096_regfile_sb.sv
module tb_ysyx_23060096_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration: ADDR_WIDTH=5, DATA_WIDTH=32, NREAD=2
  logic        rst;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        w_en;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic        init_done;

  // Wide configuration: NREAD=4, DATA_WIDTH=64
  logic         rst_w;
  logic [19:0]  raddr_w;
  logic [255:0] rdata_w;
  logic [3:0]   rbusy_w;
  logic         w_en_w;
  logic [4:0]   waddr_w;
  logic [63:0]  wdata_w;
  logic         iss_valid_w;
  logic [4:0]   iss_rd_w;
  logic         iss_ready_w;
  logic         init_done_w;

  ysyx_23060096_regfile_sb dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .w_en(w_en), .waddr(waddr), .wdata(wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .init_done(init_done)
  );

  ysyx_23060096_regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(64), .NREAD(4)) dut_w (
    .clk(clk), .rst(rst_w), .raddr(raddr_w), .rdata(rdata_w), .rbusy(rbusy_w),
    .w_en(w_en_w), .waddr(waddr_w), .wdata(wdata_w),
    .iss_valid(iss_valid_w), .iss_rd(iss_rd_w), .iss_ready(iss_ready_w),
    .init_done(init_done_w)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] e;
  logic [31:0] m_rf [32];

  task automatic wait_init(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk); cnt++; #1;
    end while (!init_done && cnt < 100);
  endtask

  task automatic test_reset;
    int cnt;
    @(negedge clk); @(negedge clk);
    raddr = {5'd9, 5'd0}; iss_valid = 1'b1; iss_rd = 5'd4;
    #1;
    n_tests++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL rst_init_done: got %b expected 0", init_done); end
    n_tests++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL rst_iss_ready: got %b expected 0", iss_ready); end
    n_tests++; if (rdata !== 64'h0) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0", rdata); end
    n_tests++; if (rbusy !== 2'b00) begin n_fail++; $display("FAIL rst_rbusy: got %b expected 00", rbusy); end
    // Hold a write and an issue throughout INIT; both must be ignored.
    @(negedge clk);
    rst = 1'b0; w_en = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5;
    raddr = {5'd4, 5'd3};
    #1;
    n_tests++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL init_iss_ready: got %b expected 0", iss_ready); end
    n_tests++; if (rdata[31:0] !== 32'h0) begin n_fail++; $display("FAIL init_bypass: got %h expected 0", rdata[31:0]); end
    wait_init(cnt);
    w_en = 1'b0; iss_valid = 1'b0;
    n_tests++; if (cnt !== 32 || init_done !== 1'b1) begin n_fail++; $display("FAIL init_cycles: got %0d expected 32", cnt); end
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      raddr = {5'(i + 16), 5'(i)};
      exp_q.push_back({32'h0, m_rf[i]});
      exp_q.push_back({32'h0, m_rf[i + 16]});
      #1;
      e = exp_q.pop_front();
      n_tests++; if (rdata[31:0] !== e[31:0]) begin n_fail++; $display("FAIL sweep_p0[%0d]: got %h expected %h", i, rdata[31:0], e[31:0]); end
      e = exp_q.pop_front();
      n_tests++; if (rdata[63:32] !== e[31:0]) begin n_fail++; $display("FAIL sweep_p1[%0d]: got %h expected %h", i + 16, rdata[63:32], e[31:0]); end
      n_tests++; if (rbusy !== 2'b00) begin n_fail++; $display("FAIL sweep_rbusy[%0d]: got %b expected 00", i, rbusy); end
    end
  endtask

  task automatic test_write_bypass;
    @(negedge clk);
    w_en = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr = {5'd5, 5'd5};
    exp_q.push_back(64'hDEADBEEF); exp_q.push_back(64'hDEADBEEF);
    #1;
    e = exp_q.pop_front();
    n_tests++; if (rdata[31:0] !== e[31:0]) begin n_fail++; $display("FAIL bypass_p0: got %h expected %h", rdata[31:0], e[31:0]); end
    e = exp_q.pop_front();
    n_tests++; if (rdata[63:32] !== e[31:0]) begin n_fail++; $display("FAIL bypass_p1: got %h expected %h", rdata[63:32], e[31:0]); end
    @(negedge clk);
    m_rf[5] = 32'hDEADBEEF;
    w_en = 1'b0;
    exp_q.push_back({32'h0, m_rf[5]});
    #1;
    e = exp_q.pop_front();
    n_tests++; if (rdata[31:0] !== e[31:0]) begin n_fail++; $display("FAIL stored_r5: got %h expected %h", rdata[31:0], e[31:0]); end
    @(negedge clk);
    w_en = 1'b1; waddr = 5'd0; wdata = 32'h1234; raddr = {5'd5, 5'd0};
    exp_q.push_back(64'h0);
    #1;
    e = exp_q.pop_front();
    n_tests++; if (rdata[31:0] !== e[31:0]) begin n_fail++; $display("FAIL r0_bypass: got %h expected %h", rdata[31:0], e[31:0]); end
    @(negedge clk);
    w_en = 1'b0;
    exp_q.push_back(64'h0); exp_q.push_back({32'h0, m_rf[5]});
    #1;
    e = exp_q.pop_front();
    n_tests++; if (rdata[31:0] !== e[31:0]) begin n_fail++; $display("FAIL r0_stored: got %h expected %h", rdata[31:0], e[31:0]); end
    e = exp_q.pop_front();
    n_tests++; if (rdata[63:32] !== e[31:0]) begin n_fail++; $display("FAIL r5_kept: got %h expected %h", rdata[63:32], e[31:0]); end
  endtask

  task automatic test_busy;
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd7; raddr = {5'd0, 5'd7};
    #1;
    n_tests++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL iss7_ready: got %b expected 1", iss_ready); end
    n_tests++; if (rbusy !== 2'b00) begin n_fail++; $display("FAIL iss7_pre_busy: got %b expected 00", rbusy); end
    @(negedge clk);
    #1;
    n_tests++; if (rbusy !== 2'b01) begin n_fail++; $display("FAIL iss7_busy: got %b expected 01", rbusy); end
    n_tests++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL iss7_waw: got %b expected 0", iss_ready); end
    @(negedge clk);
    iss_valid = 1'b0; w_en = 1'b1; waddr = 5'd7; wdata = 32'h77;
    #1;
    n_tests++; if (rbusy !== 2'b01) begin n_fail++; $display("FAIL wb7_same_cycle_busy: got %b expected 01", rbusy); end
    @(negedge clk);
    m_rf[7] = 32'h77;
    w_en = 1'b0;
    exp_q.push_back({32'h0, m_rf[7]});
    #1;
    e = exp_q.pop_front();
    n_tests++; if (rbusy !== 2'b00) begin n_fail++; $display("FAIL wb7_cleared: got %b expected 00", rbusy); end
    n_tests++; if (rdata[31:0] !== e[31:0]) begin n_fail++; $display("FAIL wb7_data: got %h expected %h", rdata[31:0], e[31:0]); end
    // Issue to register 0 is accepted but never marks busy.
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd0; raddr = {5'd0, 5'd0};
    #1;
    n_tests++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL iss0_ready: got %b expected 1", iss_ready); end
    @(negedge clk);
    iss_valid = 1'b0;
    #1;
    n_tests++; if (rbusy !== 2'b00) begin n_fail++; $display("FAIL r0_busy: got %b expected 00", rbusy); end
  endtask

  task automatic test_same_cycle;
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd3;
    @(negedge clk);
    w_en = 1'b1; waddr = 5'd3; wdata = 32'h33; raddr = {5'd0, 5'd3};
    #1;
    n_tests++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL same_ready: got %b expected 1", iss_ready); end
    @(negedge clk);
    m_rf[3] = 32'h33;
    w_en = 1'b0; iss_valid = 1'b0;
    exp_q.push_back({32'h0, m_rf[3]});
    #1;
    e = exp_q.pop_front();
    n_tests++; if (rdata[31:0] !== e[31:0]) begin n_fail++; $display("FAIL same_data: got %h expected %h", rdata[31:0], e[31:0]); end
    n_tests++; if (rbusy !== 2'b01) begin n_fail++; $display("FAIL same_busy: got %b expected 01", rbusy); end
    @(negedge clk);
    w_en = 1'b1; waddr = 5'd3; wdata = 32'h33;
    @(negedge clk);
    w_en = 1'b0;
  endtask

  task automatic test_reset_mid;
    int cnt;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    n_tests++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL midinit_done: got %b expected 0", init_done); end
    @(negedge clk); rst = 1'b0;
    wait_init(cnt);
    n_tests++; if (cnt !== 32 || init_done !== 1'b1) begin n_fail++; $display("FAIL midinit_cycles: got %0d expected 32", cnt); end
    @(negedge clk);
    w_en = 1'b1; waddr = 5'd9; wdata = 32'h99; iss_valid = 1'b1; iss_rd = 5'd12;
    @(negedge clk);
    w_en = 1'b0; iss_valid = 1'b0; raddr = {5'd12, 5'd9};
    exp_q.push_back(64'h99);
    #1;
    e = exp_q.pop_front();
    n_tests++; if (rdata[31:0] !== e[31:0]) begin n_fail++; $display("FAIL midrun_pre_data: got %h expected %h", rdata[31:0], e[31:0]); end
    n_tests++; if (rbusy !== 2'b10) begin n_fail++; $display("FAIL midrun_pre_busy: got %b expected 10", rbusy); end
    @(negedge clk); rst = 1'b1;
    #1;
    n_tests++; if (rdata !== 64'h0 || rbusy !== 2'b00 || iss_ready !== 1'b0) begin n_fail++; $display("FAIL midrun_rst_outputs: got %h/%b/%b expected 0/00/0", rdata, rbusy, iss_ready); end
    @(negedge clk); rst = 1'b0;
    wait_init(cnt);
    n_tests++; if (cnt !== 32 || init_done !== 1'b1) begin n_fail++; $display("FAIL midrun_cycles: got %0d expected 32", cnt); end
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    @(negedge clk);
    iss_rd = 5'd12;
    exp_q.push_back({32'h0, m_rf[9]});
    #1;
    e = exp_q.pop_front();
    n_tests++; if (rdata[31:0] !== e[31:0]) begin n_fail++; $display("FAIL midrun_r9: got %h expected %h", rdata[31:0], e[31:0]); end
    n_tests++; if (rbusy !== 2'b00) begin n_fail++; $display("FAIL midrun_busy: got %b expected 00", rbusy); end
    n_tests++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL midrun_ready12: got %b expected 1", iss_ready); end
  endtask

  task automatic test_wide;
    int cnt;
    logic [63:0] vals [5];
    @(negedge clk); rst_w = 1'b0;
    cnt = 0;
    do begin @(posedge clk); cnt++; #1; end while (!init_done_w && cnt < 100);
    n_tests++; if (cnt !== 32 || init_done_w !== 1'b1) begin n_fail++; $display("FAIL wide_init: got %0d expected 32", cnt); end
    for (int i = 1; i <= 4; i++) begin
      vals[i] = {32'hC0DE0000 + 32'(i), 32'h12345678 ^ 32'(i * 3)};
      @(negedge clk);
      w_en_w = 1'b1; waddr_w = 5'(i); wdata_w = vals[i];
    end
    @(negedge clk);
    w_en_w = 1'b0; raddr_w = {5'd1, 5'd2, 5'd3, 5'd4};
    for (int k = 0; k < 4; k++) exp_q.push_back(vals[4 - k]);
    #1;
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      n_tests++; if (rdata_w[k*64 +: 64] !== e) begin n_fail++; $display("FAIL wide_read_p%0d: got %h expected %h", k, rdata_w[k*64 +: 64], e); end
    end
    @(negedge clk);
    w_en_w = 1'b1; waddr_w = 5'd10; wdata_w = 64'hFEEDFACE_0BADF00D; raddr_w = {4{5'd10}};
    for (int k = 0; k < 4; k++) exp_q.push_back(64'hFEEDFACE_0BADF00D);
    #1;
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      n_tests++; if (rdata_w[k*64 +: 64] !== e) begin n_fail++; $display("FAIL wide_bypass_p%0d: got %h expected %h", k, rdata_w[k*64 +: 64], e); end
    end
    @(negedge clk);
    w_en_w = 1'b0;
    for (int k = 0; k < 4; k++) exp_q.push_back(64'hFEEDFACE_0BADF00D);
    #1;
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      n_tests++; if (rdata_w[k*64 +: 64] !== e) begin n_fail++; $display("FAIL wide_stored_p%0d: got %h expected %h", k, rdata_w[k*64 +: 64], e); end
    end
  endtask

  initial begin
    rst = 1'b1; raddr = '0; w_en = 1'b0; waddr = '0; wdata = '0;
    iss_valid = 1'b0; iss_rd = '0;
    rst_w = 1'b1; raddr_w = '0; w_en_w = 1'b0; waddr_w = '0; wdata_w = '0;
    iss_valid_w = 1'b0; iss_rd_w = '0;
    test_reset();
    test_write_bypass();
    test_busy();
    test_same_cycle();
    test_reset_mid();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
